// File: rtl/bch_pkg.sv
// Shared BCH definitions: encoder state enum, ceil_div helper and
// GF(2^13) generator polynomials built from the field at elaboration time.
package bch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } bch_enc_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // GF(2^13) with primitive polynomial x^13 + x^4 + x^3 + x + 1
    localparam logic [12:0] GF13_POLY_LOW = 13'h001B;
    localparam int unsigned GF13_ORDER    = 8191;
    localparam int unsigned BCH_M13_MAX_R = 104;

    function automatic logic [12:0] gf13_mul(input logic [12:0] a, input logic [12:0] b);
        logic [12:0] acc;
        logic [12:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 13; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[12] ? ((x << 1) ^ GF13_POLY_LOW) : (x << 1);
        end
        return acc;
    endfunction

    function automatic logic [12:0] gf13_pow(input logic [12:0] a, input logic [12:0] e);
        logic [12:0] res;
        logic [12:0] base;
        res  = 13'd1;
        base = a;
        for (int i = 0; i < 13; i++) begin
            if (e[i]) res = gf13_mul(res, base);
            base = gf13_mul(base, base);
        end
        return res;
    endfunction

    // g(x) = product of (x + a^(i*2^k)) over odd i < 2t; valid for t <= 8.
    // Coefficients are GF(2^13) elements held 13 bits apart; the finished
    // product lies in GF(2), so bit 0 of each coefficient is the g(x) bit.
    function automatic logic [BCH_M13_MAX_R:0] bch_m13_gen(input int unsigned t);
        logic [(BCH_M13_MAX_R+1)*13-1:0] c;
        logic [BCH_M13_MAX_R:0]          g;
        logic [12:0]                     root;
        int unsigned                     e;
        c       = '0;
        c[12:0] = 13'd1;
        for (int unsigned i = 1; i < 2 * t; i = i + 2) begin
            e = i;
            for (int k = 0; k < 13; k++) begin
                root = gf13_pow(13'd2, 13'(e));
                for (int j = BCH_M13_MAX_R; j >= 1; j--) begin
                    c[j*13 +: 13] = c[(j-1)*13 +: 13] ^ gf13_mul(root, c[j*13 +: 13]);
                end
                c[12:0] = gf13_mul(root, c[12:0]);
                e = (e * 2) % GF13_ORDER;
            end
        end
        for (int j = 0; j <= BCH_M13_MAX_R; j++) begin
            g[j] = c[j*13];
        end
        return g;
    endfunction

    localparam logic [13:0]            BCH_G_M13_T1 = 14'h201B;
    localparam logic [BCH_M13_MAX_R:0] BCH_G_M13_T8 = bch_m13_gen(8);

endpackage

// File: rtl/bch_encoder_pn_if.sv
// Streaming port bundle of the BCH encoder.
//   abort              : synchronous frame drop
//   in_valid/in_ready  : message word handshake, in_data bit 0 earliest
//   out_valid/out_ready: codeword word handshake, out_data bit 0 earliest
//   out_sof/out_last   : first codeword word / final parity word
// master = frame source + sink side, slave = encoder side.
interface bch_encoder_pn_if #(
    parameter int unsigned P = 8
);
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_data;
    logic         out_sof;
    logic         out_last;

    modport master (
        output abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_last
    );

    modport slave (
        input  abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_last
    );
endinterface

// File: rtl/bch_par_lfsr.sv
// P-bit-per-cycle BCH remainder update: P serial LFSR steps folded into one
// combinational stage. in_data bit 0 is consumed first.
//   in_data : message word
//   r       : current remainder
//   r_next  : remainder after absorbing in_data
module bch_par_lfsr #(
    parameter int unsigned P        = 8,
    parameter int unsigned R        = 104,
    parameter logic [R:0]  GEN_POLY = {1'b1, {(R-1){1'b0}}, 1'b1}
) (
    input  logic [P-1:0] in_data,
    input  logic [R-1:0] r,
    output logic [R-1:0] r_next
);
    logic fb;

    always_comb begin
        r_next = r;
        fb     = 1'b0;
        for (int unsigned i = 0; i < P; i++) begin
            fb     = in_data[i] ^ r_next[R-1];
            r_next = (r_next << 1) ^ ({R{fb}} & GEN_POLY[R-1:0]);
        end
    end
endmodule

// File: rtl/bch_encoder_pn.sv
// Streaming systematic BCH encoder: echoes K/P message words, then appends
// the R-bit remainder as ceil(R/P) parity words. One output register with
// valid/ready backpressure; abort drops the frame in progress.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of bch_encoder_pn_if (handshakes, abort, sof/last)
module bch_encoder_pn
    import bch_pkg::*;
#(
    parameter int unsigned P        = 8,
    parameter int unsigned K        = 4096,
    parameter int unsigned R        = 104,
    parameter logic [R:0]  GEN_POLY = BCH_G_M13_T8
) (
    input  logic            clk,
    input  logic            reset,
    bch_encoder_pn_if.slave bus
);
    localparam int unsigned NDB   = K / P;
    localparam int unsigned NPB   = ceil_div(R, P);
    localparam int unsigned LASTW = R - (NPB - 1) * P;
    localparam int unsigned BW    = $clog2(NDB + NPB);

    if (P < 1) begin : g_bad_p
        $error("bch_encoder_pn: P must be >= 1");
    end
    if (K % P != 0) begin : g_bad_k
        $error("bch_encoder_pn: K must be a multiple of P");
    end
    if (GEN_POLY[R] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
        $error("bch_encoder_pn: GEN_POLY bits R and 0 must be set");
    end

    bch_enc_state_t state_q, state_n;
    logic [BW-1:0]  beat_q, beat_n;
    logic [R-1:0]   r_q, r_n, r_upd;
    logic [R-1:0]   ps_q, ps_n;
    logic [P-1:0]   out_data_q, out_data_n;
    logic           out_valid_q, out_valid_n;
    logic           out_sof_q, out_sof_n;
    logic           out_last_q, out_last_n;
    logic [P-1:0]   par_word;
    logic           out_free, in_ready_c, in_fire, data_last, par_last;

    bch_par_lfsr #(
        .P        (P),
        .R        (R),
        .GEN_POLY (GEN_POLY)
    ) u_lfsr (
        .in_data (bus.in_data),
        .r       (r_q),
        .r_next  (r_upd)
    );

    // Next parity word: MSB of ps goes out first; the tail of the last word is zero
    always_comb begin
        par_word = '0;
        for (int unsigned i = 0; i < P; i++) begin
            if (i < R && (!par_last || i < LASTW)) begin
                par_word[i] = ps_q[R-1-i];
            end
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_n     = state_q;
        beat_n      = beat_q;
        r_n         = r_q;
        ps_n        = ps_q;
        out_data_n  = out_data_q;
        out_valid_n = out_valid_q;
        out_sof_n   = out_sof_q;
        out_last_n  = out_last_q;

        out_free   = !out_valid_q || bus.out_ready;
        in_ready_c = (state_q != ST_PARITY) && out_free && !reset;
        in_fire    = in_ready_c && bus.in_valid;
        data_last  = (beat_q == BW'(NDB - 1));
        par_last   = (beat_q == BW'(NDB + NPB - 1));

        if (bus.abort) begin
            state_n     = ST_IDLE;
            beat_n      = '0;
            r_n         = '0;
            ps_n        = '0;
            out_data_n  = '0;
            out_valid_n = 1'b0;
            out_sof_n   = 1'b0;
            out_last_n  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DATA: begin
                    if (in_fire) begin
                        out_data_n  = bus.in_data;
                        out_valid_n = 1'b1;
                        out_sof_n   = (state_q == ST_IDLE);
                        out_last_n  = 1'b0;
                        if (data_last) begin
                            // Remainder is complete: hand it to ps, r is clean for the next frame
                            state_n = ST_PARITY;
                            ps_n    = r_upd;
                            r_n     = '0;
                            beat_n  = BW'(NDB);
                        end else begin
                            state_n = ST_DATA;
                            r_n     = r_upd;
                            beat_n  = beat_q + 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_n = 1'b0;
                        out_sof_n   = 1'b0;
                        out_last_n  = 1'b0;
                    end
                end
                ST_PARITY: begin
                    // out_valid is always set here; each sink accept advances one word
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_n     = ST_IDLE;
                            beat_n      = '0;
                            out_valid_n = 1'b0;
                            out_sof_n   = 1'b0;
                            out_last_n  = 1'b0;
                        end else begin
                            out_data_n = par_word;
                            out_sof_n  = 1'b0;
                            out_last_n = par_last;
                            ps_n       = ps_q << P;
                            if (!par_last) beat_n = beat_q + 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            r_q         <= '0;
            ps_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            beat_q      <= beat_n;
            r_q         <= r_n;
            ps_q        <= ps_n;
            out_data_q  <= out_data_n;
            out_valid_q <= out_valid_n;
            out_sof_q   <= out_sof_n;
            out_last_q  <= out_last_n;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_bch_encoder_pn.sv
// Scoreboard bench for bch_encoder_pn with P=16 (NPB=7, LASTW=8).
// Expected codewords come from polynomial long division over the message bits.
module tb_bch_encoder_pn;
    import bch_pkg::*;

    localparam int unsigned P   = 16;
    localparam int unsigned K   = 4096;
    localparam int unsigned R   = 104;
    localparam int unsigned NDB = K / P;
    localparam int unsigned NPB = (R + P - 1) / P;
    localparam logic [R:0]  G   = BCH_G_M13_T8;

    typedef struct packed {
        logic [P-1:0] data;
        logic         sof;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    bit   bp_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc = 0;
    int unsigned out_beats = 0;
    beat_t exp_q[$];
    bit [P-1:0] words [NDB];
    bit         a [K+R];

    bch_encoder_pn_if #(.P(P)) enc_if ();

    bch_encoder_pn #(
        .P        (P),
        .K        (K),
        .R        (R),
        .GEN_POLY (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (enc_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink ready: always 1, or a fair coin per cycle in backpressure mode
    initial begin
        enc_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            enc_if.out_ready = bp_mode ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Monitor: pop and compare on every transfer; check stability while stalled
    logic [P+1:0] held;
    bit           held_v = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && enc_if.out_valid) begin
                checks++;
                if ({enc_if.out_data, enc_if.out_sof, enc_if.out_last} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h expected %0h",
                             {enc_if.out_data, enc_if.out_sof, enc_if.out_last}, held);
                end
            end
            held_v = 1'b0;
            if (enc_if.out_valid && enc_if.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat %0d: got data %0h sof %0b last %0b",
                             out_beats, enc_if.out_data, enc_if.out_sof, enc_if.out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({enc_if.out_data, enc_if.out_sof, enc_if.out_last} !== e) begin
                        errors++;
                        $display("FAIL beat %0d: got data %0h sof %0b last %0b expected data %0h sof %0b last %0b",
                                 out_beats, enc_if.out_data, enc_if.out_sof, enc_if.out_last,
                                 e.data, e.sof, e.last);
                    end
                end
                out_beats++;
            end else if (enc_if.out_valid) begin
                held   = {enc_if.out_data, enc_if.out_sof, enc_if.out_last};
                held_v = 1'b1;
            end
        end
    end

    // kind 0: all zero, 1: only bit 0 of beat 0, 2: random
    task automatic make_frame(input int kind);
        for (int b = 0; b < int'(NDB); b++) begin
            words[b] = (kind == 2) ? P'($urandom()) : '0;
        end
        if (kind == 1) words[0][0] = 1'b1;
    endtask

    // Expected beats: message echoed, then M(x)*x^R mod g(x), highest degree first
    task automatic push_frame(input int n_data, input bit with_parity);
        bit [P-1:0] pw;
        for (int b = 0; b < n_data; b++) begin
            exp_q.push_back('{data: words[b], sof: (b == 0), last: 1'b0});
        end
        if (with_parity) begin
            for (int n = 0; n < int'(K + R); n++) begin
                a[n] = (n < int'(K)) ? words[n / P][n % P] : 1'b0;
            end
            for (int n = 0; n < int'(K); n++) begin
                if (a[n]) begin
                    for (int t = 0; t <= int'(R); t++) a[n + t] = a[n + t] ^ G[int'(R) - t];
                end
            end
            for (int j = 0; j < int'(NPB); j++) begin
                pw = '0;
                for (int i = 0; i < int'(P); i++) begin
                    if (j * P + i < R) pw[i] = a[K + j * P + i];
                end
                exp_q.push_back('{data: pw, sof: 1'b0, last: (j == int'(NPB) - 1)});
            end
        end
    endtask

    task automatic wait_accept(output int unsigned c);
        bit ok = 1'b0;
        c = 0;
        for (int g = 0; g < 4000 && !ok; g++) begin
            @(negedge clk);
            ok = enc_if.in_ready;
            c  = cyc;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
    endtask

    task automatic send_words(input int n, input bit gaps, output int unsigned first_cyc);
        int unsigned c;
        first_cyc = 0;
        for (int b = 0; b < n; b++) begin
            if (gaps) begin
                while ($urandom_range(3, 0) == 0) begin
                    enc_if.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            enc_if.in_valid = 1'b1;
            enc_if.in_data  = words[b];
            wait_accept(c);
            if (b == 0) first_cyc = c;
        end
        enc_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 20000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c1, c2, cd;

        reset           = 1'b1;
        enc_if.abort    = 1'b0;
        enc_if.in_valid = 1'b0;
        enc_if.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(enc_if.out_valid), 64'd0);
        chk("rst_out_data",  64'(enc_if.out_data),  64'd0);
        chk("rst_out_sof",   64'(enc_if.out_sof),   64'd0);
        chk("rst_out_last",  64'(enc_if.out_last),  64'd0);
        chk("rst_in_ready",  64'(enc_if.in_ready),  64'd0);
        reset = 1'b0;

        // Zero, single-bit and random frames without backpressure
        for (int kind = 0; kind < 3; kind++) begin
            make_frame(kind);
            push_frame(NDB, 1'b1);
            send_words(NDB, 1'b0, c1);
            wait_drain("frame_kind");
        end

        // Back-to-back frames: period is NDB+NPB+1 cycles
        make_frame(2);
        push_frame(NDB, 1'b1);
        send_words(NDB, 1'b0, c1);
        make_frame(2);
        push_frame(NDB, 1'b1);
        send_words(NDB, 1'b0, c2);
        chk("frame_period", 64'(c2 - c1), 64'(NDB + NPB + 1));
        wait_drain("back_to_back");

        // Abort while beat 100 is offered: beats 0..99 only, no out_last
        make_frame(2);
        push_frame(100, 1'b0);
        send_words(100, 1'b0, c1);
        enc_if.in_valid = 1'b1;
        enc_if.in_data  = words[100];
        enc_if.abort    = 1'b1;
        @(posedge clk);
        #1;
        enc_if.abort    = 1'b0;
        enc_if.in_valid = 1'b0;
        chk("abort_out_valid", 64'(enc_if.out_valid), 64'd0);
        chk("abort_in_ready",  64'(enc_if.in_ready),  64'd1);
        wait_drain("abort");
        make_frame(2);
        push_frame(NDB, 1'b1);
        send_words(NDB, 1'b0, c1);
        wait_drain("after_abort");

        // Asynchronous reset during parity emission
        make_frame(2);
        push_frame(NDB, 1'b1);
        send_words(NDB, 1'b0, c1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(enc_if.out_valid), 64'd0);
        chk("midrst_out_data",  64'(enc_if.out_data),  64'd0);
        chk("midrst_out_last",  64'(enc_if.out_last),  64'd0);
        chk("midrst_in_ready",  64'(enc_if.in_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        make_frame(2);
        push_frame(NDB, 1'b1);
        send_words(NDB, 1'b0, c1);
        wait_drain("after_reset");

        // Random backpressure and input gaps over 20 frames
        bp_mode = 1'b1;
        for (int f = 0; f < 20; f++) begin
            make_frame(2);
            push_frame(NDB, 1'b1);
            send_words(NDB, 1'b1, cd);
        end
        wait_drain("backpressure");
        bp_mode = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
